// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit_if
//  Purpose  : Bundles the control inputs and PC/RAS outputs of pc_unit.
//             master = execution FSM side, slave = pc_unit side.
//  Revision : 1.0  initial release
// ============================================================================
interface pc_unit_if #(
    parameter int PC_W      = 10,
    parameter int OFF_W     = 8,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic             adv;
    logic [2:0]       op;
    logic [OFF_W-1:0] br_off;
    logic [PC_W-1:0]  jmp_tgt;
    logic [PC_W-1:0]  pc_curr;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic             err;

    modport master (
        output adv, op, br_off, jmp_tgt,
        input  pc_curr, pc_inc, ras_top, ras_cnt, err
    );

    modport slave (
        input  adv, op, br_off, jmp_tgt,
        output pc_curr, pc_inc, ras_top, ras_cnt, err
    );
endinterface
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Program counter with sequential/branch/jump/call/return flow.
//             Return-address stack is built only when PC_UNIT_RAS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module pc_unit #(
    parameter int              PC_W      = 10,
    parameter int              OFF_W     = 8,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    pc_unit_if.slave    bus
);
    localparam logic [2:0]      c_op_seq  = 3'b000;
    localparam logic [2:0]      c_op_br   = 3'b001;
    localparam logic [2:0]      c_op_jmp  = 3'b010;
    localparam logic [2:0]      c_op_call = 3'b011;
    localparam logic [2:0]      c_op_ret  = 3'b100;
    localparam logic [PC_W-1:0] c_pc_one  = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0] r_pc;
    logic            r_err;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_off_ext;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_err_nxt;

    assign w_pc_inc  = r_pc + c_pc_one;
    assign w_off_ext = PC_W'($signed(bus.br_off));

`ifdef PC_UNIT_RAS_EN
    localparam int               CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam int               PTR_W      = $clog2(RAS_DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_one  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(RAS_DEPTH - 1);

    logic [PC_W-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;
    logic             w_ras_full;
    logic             w_ras_empty;
    logic [PC_W-1:0]  w_ras_top;
    logic             w_push;
    logic             w_pop;

    // r_ptr indexes the top entry; a push on a full stack lands on the oldest slot
    assign w_ptr_inc   = (r_ptr == c_ptr_last) ? '0 : r_ptr + c_ptr_one;
    assign w_ptr_dec   = (r_ptr == '0) ? c_ptr_last : r_ptr - c_ptr_one;
    assign w_ras_full  = (r_cnt == c_cnt_full);
    assign w_ras_empty = (r_cnt == '0);
    assign w_ras_top   = w_ras_empty ? '0 : r_ras[r_ptr];
`endif

    always_comb begin
        w_pc_nxt  = r_pc;
        w_err_nxt = 1'b0;
`ifdef PC_UNIT_RAS_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
`endif
        if (bus.adv) begin
            case (bus.op)
                c_op_seq:  w_pc_nxt = w_pc_inc;
                c_op_br:   w_pc_nxt = r_pc + w_off_ext;
                c_op_jmp:  w_pc_nxt = bus.jmp_tgt;
                c_op_call: begin
                    w_pc_nxt  = bus.jmp_tgt;
`ifdef PC_UNIT_RAS_EN
                    w_push    = 1'b1;
                    w_err_nxt = w_ras_full;
`endif
                end
                c_op_ret: begin
`ifdef PC_UNIT_RAS_EN
                    if (w_ras_empty) begin
                        w_pc_nxt  = w_pc_inc;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_pc_nxt  = w_ras_top;
                        w_pop     = 1'b1;
                    end
`else
                    w_err_nxt = 1'b1;
`endif
                end
                default:   w_err_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_VEC;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_err <= w_err_nxt;
        end
    end

`ifdef PC_UNIT_RAS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_push) begin
            r_ptr <= w_ptr_inc;
            if (!w_ras_full) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end else if (w_pop) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    // Entry storage needs no reset: ras_top is masked while the count is zero
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_ras[w_ptr_inc] <= w_pc_inc;
        end
    end

    assign bus.ras_top = w_ras_top;
    assign bus.ras_cnt = r_cnt;
`else
    assign bus.ras_top = '0;
    assign bus.ras_cnt = '0;
`endif

    assign bus.pc_curr = r_pc;
    assign bus.pc_inc  = w_pc_inc;
    assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit: the next-generation PC for the core. It holds the index of the next instruction to fetch and advances only when the execution FSM authorises it. It supports sequential, PC-relative branch, absolute jump, and call/return flow through an internal return-address stack (RAS). It sits between the execution FSM and instruction memory. It performs no decoding and no memory access.

## Interface
- PC_W, 10: program counter width in bits.
- OFF_W, 8: branch offset width, two's complement; must satisfy OFF_W ≤ PC_W.
- RESET_VEC, 0: PC value loaded on reset; PC_W bits wide.
- RAS_DEPTH, 4: return-address stack entries; must be ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- adv  in  1  FSM authorisation; PC updates on this edge only when high.
- op  in  3  flow op: 000 SEQ, 001 BR, 010 JMP, 011 CALL, 100 RET; 101–111 illegal.
- br_off  in  OFF_W  signed branch offset; used by BR only.
- jmp_tgt  in  PC_W  absolute target; used by JMP and CALL.
- pc_curr  out  PC_W  current PC, registered.
- pc_inc  out  PC_W  pc_curr + 1 modulo 2^PC_W, combinational.
- ras_top  out  PC_W  current top-of-stack entry; 0 when the stack is empty.
- ras_cnt  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- err  out  1  one-cycle registered pulse flagging an anomalous op.

## Operation
- adv=0: all state holds; op, br_off and jmp_tgt are ignored; err=0 next cycle.
- adv=1, SEQ: pc_curr ← pc_inc. PC_W'(2^PC_W−1) wraps to 0.
- adv=1, BR: pc_curr ← pc_curr + sign_extend(br_off).
  - Offset is relative to pc_curr, not pc_inc.
  - Sum is truncated to PC_W bits, so wrap-around in either direction is legal and not an error.
- adv=1, JMP: pc_curr ← jmp_tgt. RAS is unchanged.
- adv=1, CALL: push pc_inc onto the RAS; pc_curr ← jmp_tgt.
  - If the RAS is full, the oldest entry is overwritten (circular buffer), ras_cnt stays at RAS_DEPTH, and err pulses.
- adv=1, RET with ras_cnt>0: pc_curr ← ras_top; pop; ras_cnt decrements.
- adv=1, RET with ras_cnt=0: pc_curr ← pc_inc (fall through); err pulses; ras_cnt stays 0.
- adv=1, illegal op: pc_curr and RAS hold; err pulses.
- RAS implementation:
  - Circular array with a top pointer modulo RAS_DEPTH plus a saturating count.
  - ras_top = entry at the top pointer when ras_cnt>0, otherwise 0.
- err is asserted only for full-CALL, empty-RET and illegal op. Every other case drives err=0.

## Timing
- Reset:
  - pc_curr=RESET_VEC, ras_cnt=0, ras_top=0, err=0, pointer=0.
  - Entry contents are don't-care and are never visible, because ras_top is gated by ras_cnt.
  - rst dominates adv. Reset mid-sequence discards any pending op and empties the RAS.
- Latency: an op sampled with adv=1 at edge N is visible on pc_curr, ras_cnt, ras_top and err after edge N.
- pc_inc and ras_top are combinational from registered state; no input-to-output combinational path exists.
- err is high for exactly the cycle following the offending edge. Back-to-back errors give back-to-back pulses.
- CALL and RET each complete in one cycle. CALL immediately followed by RET returns to the CALL's pc_inc.

## Configuration
- Macro: PC_UNIT_RAS_EN.
- Defined: RAS is present and operates as described above.
- Undefined:
  - No stack storage is built.
  - CALL behaves exactly as JMP, with no err.
  - RET is treated as an illegal op: PC holds and err pulses.
  - ras_cnt and ras_top are tied to 0.
  - RAS_DEPTH is ignored.

## Test plan
- Reset, then hold adv=0 for 5 cycles -> pc_curr=RESET_VEC (0), pc_inc=1, err=0 throughout. Then 3 SEQ with adv=1 -> pc_curr goes 1, 2, 3.
- Defaults, pc_curr=1020: SEQ×5 -> 1021, 1022, 1023, 0, 1. Then BR br_off=−2 at pc=1 -> 1023. BR br_off=+5 at pc=1023 -> 4.
- Nested calls: CALL 100 at pc=10, CALL 200, RET, RET.
  - pc_curr goes 100, 200, 101, 11.
  - ras_cnt goes 1, 2, 1, 0.
  - err stays 0.
- RAS overflow with RAS_DEPTH=4: five CALLs -> err pulses once on the 5th, ras_cnt=4. Five RETs -> the first four return in LIFO order, the 5th falls through to pc_inc with an err pulse.
- op=110 with adv=1 -> pc_curr unchanged, err high for one cycle. Same op with adv=0 -> err stays 0.
- Assert rst while ras_cnt=3, concurrent with adv=1 and CALL -> next cycle pc_curr=RESET_VEC, ras_cnt=0, err=0.
- With PC_UNIT_RAS_EN undefined -> CALL 50 gives pc_curr=50 and err=0; RET holds PC and pulses err.
